// File: rtl/serial_subtractor.sv
// serial_subtractor: digit-serial unsigned a - b with start/busy/done handshake
// Define SERIAL_SUB_SAT_EN to clamp diff to 0 whenever the final borrow is set.
module serial_subtractor #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic brw_q, brw_d, busy_q, busy_d, done_q, done_d, borrow_q, borrow_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, build_q, build_d, diff_q, diff_d, res;
  logic [DIGIT:0] sub;
  assign sub = {1'b0, a_q[cnt_q*DIGIT +: DIGIT]} - {1'b0, b_q[cnt_q*DIGIT +: DIGIT]}
             - (DIGIT+1)'(brw_q);
`ifdef SERIAL_SUB_SAT_EN
  assign res = brw_q ? '0 : build_q;
`else
  assign res = build_q;
`endif
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    brw_d    = brw_q;
    a_d      = a_q;
    b_d      = b_q;
    build_d  = build_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    case (state_q)
      IDLE: if (start) begin
        a_d     = a;
        b_d     = b;
        brw_d   = 1'b0;
        cnt_d   = '0;
        busy_d  = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        build_d[cnt_q*DIGIT +: DIGIT] = sub[DIGIT-1:0];
        brw_d   = sub[DIGIT];
        cnt_d   = (cnt_q == CW'(N-1)) ? '0 : cnt_q + 1'b1;
        state_d = (cnt_q == CW'(N-1)) ? DONE : RUN;
      end
      DONE: begin
        done_d   = 1'b1;
        busy_d   = 1'b0;
        diff_d   = res;
        borrow_d = brw_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      brw_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      build_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      brw_q    <= brw_d;
      a_q      <= a_d;
      b_q      <= b_d;
      build_q  <= build_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
    end
  end
  assign busy   = busy_q;
  assign done   = done_q;
  assign diff   = diff_q;
  assign borrow = borrow_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: vector table, corner sequences and random ops against an arithmetic model
module tb_serial_subtractor;
`ifdef SERIAL_SUB_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b1, start = 1'b0, s4 = 1'b0;
  logic [15:0] a = '0, b = '0, diff;
  logic [3:0] a4 = '0, b4 = '0, diff4;
  logic busy, done, borrow, busy4, done4, borrow4;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  serial_subtractor #(.WIDTH(16), .DIGIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .borrow(borrow));
  serial_subtractor #(.WIDTH(4), .DIGIT(1)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(s4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .diff(diff4), .borrow(borrow4));
  typedef struct {logic [15:0] a, b, d; logic br; int inj;} vec_t;
  vec_t tv[7];
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask
  function automatic logic [16:0] model(input logic [15:0] x, input logic [15:0] y);
    logic br;
    br = x < y;
    return {br, (SAT && br) ? 16'h0000 : 16'(x - y)};
  endfunction
  task automatic run_op(input logic [15:0] ai, input logic [15:0] bi, input int inj,
                        output logic [15:0] d, output logic br, output int lat,
                        output int busy_n, output int dones, output bit stable);
    logic [15:0] prev;
    @(negedge clk);
    prev = diff; a = ai; b = bi; start = 1'b1;
    lat = 0; busy_n = 0; dones = 0; stable = 1'b1; d = '0; br = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start = (c == inj);
      a = (c == inj) ? 16'hFFFF : 16'($urandom);
      b = (c == inj) ? 16'hFFFF : 16'($urandom);
      if (busy) busy_n++;
      if (done) begin
        dones++;
        if (lat == 0) begin lat = c; d = diff; br = borrow; end
      end else if (lat == 0 && diff !== prev) stable = 1'b0;
      if (lat != 0 && c >= lat + 8) break;
    end
    start = 1'b0;
  endtask
  task automatic check_op(input string nm, input logic [15:0] ai, input logic [15:0] bi,
                          input logic [15:0] ed, input logic eb, input int inj);
    logic [15:0] d;
    logic br;
    int lat, busy_n, dones;
    bit stable;
    run_op(ai, bi, inj, d, br, lat, busy_n, dones, stable);
    chk({nm, "_diff"}, d, ed);
    chk({nm, "_borrow"}, br, eb);
    chk({nm, "_latency"}, lat, 6);
    chk({nm, "_busy_cycles"}, busy_n, 5);
    chk({nm, "_done_pulses"}, dones, 1);
    chk({nm, "_diff_stable"}, stable, 1);
  endtask
  initial begin
    int quiet;
    logic [16:0] m;
    logic [15:0] x, y;
    logic [3:0] x4, y4, ed4;
    int lat4;
    tv[0] = '{16'h1234, 16'h0234, 16'h1000, 1'b0, 0};
    tv[1] = '{16'h0000, 16'h0001, SAT ? 16'h0000 : 16'hFFFF, 1'b1, 0};
    tv[2] = '{16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 0};
    tv[3] = '{16'h0000, 16'hFFFF, SAT ? 16'h0000 : 16'h0001, 1'b1, 0};
    tv[4] = '{16'h8000, 16'h7FFF, 16'h0001, 1'b0, 0};
    tv[5] = '{16'h0800, 16'h0001, 16'h07FF, 1'b0, 2};
    tv[6] = '{16'h0800, 16'h0001, 16'h07FF, 1'b0, 5};
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_diff", diff, 0);
    chk("rst_borrow", borrow, 0);
    rst_n = 1'b1;
    quiet = 0;
    repeat (10) begin @(negedge clk); if (done || busy) quiet++; end
    chk("idle_no_activity", quiet, 0);
    foreach (tv[i]) check_op($sformatf("vec%0d", i), tv[i].a, tv[i].b, tv[i].d, tv[i].br, tv[i].inj);
    @(negedge clk);
    a = 16'h1234; b = 16'h0001; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_diff", diff, 0);
    chk("midrst_borrow", borrow, 0);
    @(negedge clk);
    rst_n = 1'b1;
    quiet = 0;
    repeat (12) begin @(negedge clk); if (done || busy) quiet++; end
    chk("midrst_no_done", quiet, 0);
    check_op("after_rst", 16'd5, 16'd3, 16'h0002, 1'b0, 0);
    for (int i = 0; i < 40; i++) begin
      x = 16'($urandom);
      y = (i % 8 == 0) ? x : 16'($urandom);
      m = model(x, y);
      check_op("rand", x, y, m[15:0], m[16], 0);
    end
    @(negedge clk);
    for (int i = 0; i < 256; i++) begin
      x4 = 4'(i >> 4);
      y4 = 4'(i);
      a4 = x4; b4 = y4; s4 = 1'b1;
      lat4 = 0;
      for (int c = 1; c <= 12; c++) begin
        @(negedge clk);
        if (done4) begin lat4 = c; break; end
        a4 = 4'($urandom);
        b4 = 4'($urandom);
      end
      ed4 = (SAT && x4 < y4) ? 4'h0 : 4'(x4 - y4);
      chk($sformatf("w4_%0h_%0h", x4, y4), {diff4, borrow4, 8'(lat4)}, {ed4, x4 < y4, 8'd6});
    end
    s4 = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
